// File: rtl/s2p_frame_ctrl.sv
// Frame controller for the serial-to-parallel I/Q demux path: sync hunt, 4-slot symbol
// assembly (I[1],Q[1],I[0],Q[0]) and a 2-entry valid/ready output FIFO.
module s2p_frame_ctrl #(
  parameter int unsigned          SYNC_LEN   = 8,
  parameter logic [SYNC_LEN-1:0]  SYNC_WORD  = SYNC_LEN'(8'hA5),
  parameter int unsigned          FRAME_SYMS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        srl_bit,
  input  logic        srl_valid,
  output logic [1:0]  sym_i,
  output logic [1:0]  sym_q,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        locked,
  output logic        frame_done,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [15:0] frame_cnt
);

  localparam int unsigned SR_W  = SYNC_LEN - 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SYM_W = 4;

  typedef enum logic {HUNT, LOCK} state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [1:0]         slot_q, slot_d;
  logic [2:0]         part_q, part_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SYM_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic               head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic               ovf_q, ovf_d;
  logic               fdone_q, fdone_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic [SYNC_LEN-1:0] sr_shift;
  logic                push, pop, drop;
  logic [SYM_W-1:0]    new_sym;

  assign sr_shift = {sr_q, srl_bit};

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      sr_q     <= '0;
      slot_q   <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      head_v_q <= 1'b0;
      tail_q   <= '0;
      tail_v_q <= 1'b0;
      ovf_q    <= 1'b0;
      fdone_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      slot_q   <= slot_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      head_v_q <= head_v_d;
      tail_q   <= tail_d;
      tail_v_q <= tail_v_d;
      ovf_q    <= ovf_d;
      fdone_q  <= fdone_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Next-state: sync hunt, slot sequencing, frame accounting, FIFO update
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    slot_d   = slot_q;
    part_d   = part_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    head_v_d = head_v_q;
    tail_d   = tail_q;
    tail_v_d = tail_v_q;
    ovf_d    = ovf_q;
    fdone_d  = 1'b0;
    fcnt_d   = fcnt_q;
    push     = 1'b0;
    new_sym  = '0;

    case (state_q)
      HUNT: begin
        if (!en) begin
          sr_d = '0;
        end else if (srl_valid) begin
          sr_d   = sr_shift[SR_W-1:0];
          slot_d = '0;
          cnt_d  = '0;
          if (sr_shift == SYNC_WORD) state_d = LOCK;
        end
      end
      LOCK: begin
        if (!en) begin
          state_d = HUNT;
          sr_d    = '0;
          slot_d  = '0;
          cnt_d   = '0;
        end else if (srl_valid) begin
          slot_d = slot_q + 2'd1;
          case (slot_q)
            2'd0:    part_d[2] = srl_bit;
            2'd1:    part_d[1] = srl_bit;
            2'd2:    part_d[0] = srl_bit;
            default: begin
              push    = 1'b1;
              new_sym = {part_q[2], part_q[0], part_q[1], srl_bit};
              cnt_d   = cnt_q + CNT_W'(1);
              // Last payload symbol: clear sr so trailing payload cannot fake a sync
              if (cnt_q == CNT_W'(FRAME_SYMS - 1)) begin
                state_d = HUNT;
                sr_d    = '0;
                cnt_d   = '0;
                fdone_d = 1'b1;
                fcnt_d  = fcnt_q + 16'd1;
              end
            end
          endcase
        end
      end
      default: state_d = HUNT;
    endcase

    pop  = head_v_q & sym_ready;
    drop = push & head_v_q & tail_v_q & ~pop;

    if (pop) begin
      head_d   = tail_q;
      head_v_d = tail_v_q;
      tail_d   = '0;
      tail_v_d = 1'b0;
    end
    if (push) begin
      if (!head_v_d) begin
        head_d   = new_sym;
        head_v_d = 1'b1;
      end else if (!tail_v_d) begin
        tail_d   = new_sym;
        tail_v_d = 1'b1;
      end
    end

    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  assign sym_i      = head_q[3:2];
  assign sym_q      = head_q[1:0];
  assign sym_valid  = head_v_q;
  assign locked     = (state_q == LOCK);
  assign frame_done = fdone_q;
  assign overflow   = ovf_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Scoreboard bench for s2p_frame_ctrl: directed scenarios plus random serial traffic
// checked against a bit-queue reference model.
module tb_s2p_frame_ctrl;

  localparam logic [7:0] SW = 8'hA5;
  localparam int         FS = 16;

  logic        clk = 1'b0;
  logic        rst, en, srl_bit, srl_valid, sym_ready, clr_ovf;
  logic [1:0]  sym_i, sym_q;
  logic        sym_valid, locked, frame_done, overflow;
  logic [15:0] frame_cnt;

  s2p_frame_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .srl_bit(srl_bit), .srl_valid(srl_valid),
    .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .locked(locked), .frame_done(frame_done), .overflow(overflow),
    .clr_ovf(clr_ovf), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bit history, collected payload bits, expected FIFO contents
  logic [3:0] sb_q[$];
  bit         hist[$];
  bit         pbits[$];
  int         m_cnt, m_syms, m_fcnt;
  bit         m_lock, m_fd, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void hist_clear();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
  endfunction

  function automatic void model_reset();
    hist_clear();
    pbits.delete();
    sb_q.delete();
    m_cnt = 0; m_syms = 0; m_fcnt = 0;
    m_lock = 0; m_fd = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge(input bit b, v, e, r, c);
    int  popped, pushed;
    bit  drop;
    logic [7:0] w;
    logic [3:0] sym;
    popped = (m_cnt > 0 && r) ? 1 : 0;
    pushed = 0;
    drop   = 0;
    m_fd   = 0;
    if (!e) begin
      m_lock = 0;
      hist_clear();
      pbits.delete();
      m_syms = 0;
    end else if (!m_lock) begin
      if (v) begin
        hist.push_back(b);
        void'(hist.pop_front());
        w = '0;
        for (int i = 0; i < 8; i++) w = {w[6:0], hist[i]};
        if (w == SW) begin
          m_lock = 1;
          pbits.delete();
          m_syms = 0;
        end
      end
    end else if (v) begin
      pbits.push_back(b);
      if (pbits.size() == 4) begin
        sym = {pbits[0], pbits[2], pbits[1], pbits[3]};
        pbits.delete();
        if (m_cnt - popped < 2) begin
          sb_q.push_back(sym);
          pushed = 1;
        end else begin
          drop = 1;
        end
        m_syms++;
        if (m_syms == FS) begin
          m_lock = 0;
          m_fd   = 1;
          m_fcnt = (m_fcnt + 1) % 65536;
          hist_clear();
          m_syms = 0;
        end
      end
    end
    m_cnt = m_cnt - popped + pushed;
    if (c)    m_ovf = 0;
    if (drop) m_ovf = 1;
  endfunction

  task automatic step(input bit b, v, e, r, c);
    srl_bit = b; srl_valid = v; en = e; sym_ready = r; clr_ovf = c;
    model_edge(b, v, e, r, c);
    @(posedge clk);
    #1;
    check("locked", int'(locked), int'(m_lock));
    check("frame_done", int'(frame_done), int'(m_fd));
    check("overflow", int'(overflow), int'(m_ovf));
    check("frame_cnt", int'(frame_cnt), m_fcnt);
    check("sym_valid", int'(sym_valid), (m_cnt > 0) ? 1 : 0);
    if (m_cnt == 0) check("empty_data", int'({sym_i, sym_q}), 0);
  endtask

  task automatic send_bits(input logic [7:0] val, input int n, input bit r);
    logic [7:0] t;
    t = val;
    for (int i = n - 1; i >= 0; i--) begin
      if ($urandom_range(3) == 0) step(1'b0, 1'b0, 1'b1, r, 1'b0);
      step(t[i], 1'b1, 1'b1, r, 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, r, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    srl_bit = 0; srl_valid = 0; en = 0; sym_ready = 0; clr_ovf = 0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_valid", int'(sym_valid), 0);
    check("rst_data", int'({sym_i, sym_q}), 0);
    check("rst_fdone", int'(frame_done), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_fcnt", int'(frame_cnt), 0);
    rst = 1'b0;
  endtask

  // Monitor: pop expected symbol on every accepted handshake
  initial begin
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && sym_valid && sym_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          exp = sb_q.pop_front();
          check("sym_i", int'(sym_i), int'(exp[3:2]));
          check("sym_q", int'(sym_q), int'(exp[1:0]));
        end
      end
    end
  end

  initial begin
    bit pend[$];
    bit b, v;
    do_reset();

    // Sync detection and first symbol I=3,Q=1
    send_bits(SW, 8, 1'b1);
    check("t1_lock", int'(locked), 1);
    send_bits(8'h0B, 4, 1'b1);
    check("t2_valid", int'(sym_valid), 1);
    check("t2_sym", int'({sym_i, sym_q}), 4'hD);
    idle(2, 1'b1);

    // Remainder of frame; last two symbols spell the sync word
    for (int s = 0; s < 13; s++) send_bits(8'($urandom_range(15)), 4, 1'b1);
    send_bits(SW, 8, 1'b1);
    check("t3_unlock", int'(locked), 0);
    check("t3_fcnt", int'(frame_cnt), 1);
    send_bits(8'h01, 2, 1'b1);
    check("t3_norelock", int'(locked), 0);
    idle(3, 1'b1);

    // Overflow on a full FIFO, ordered drain, clear
    send_bits(SW, 8, 1'b1);
    idle(2, 1'b1);
    send_bits(8'h12, 8, 1'b0);
    send_bits(8'h07, 4, 1'b0);
    check("t4_ovf", int'(overflow), 1);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("t4_clr", int'(overflow), 0);

    // Push and pop on the same edge while full
    send_bits(8'h9C, 8, 1'b0);
    send_bits(8'h06, 3, 1'b0);
    send_bits(8'h01, 1, 1'b1);
    check("t5_noovf", int'(overflow), 0);
    idle(3, 1'b1);

    // Abort mid-symbol, then reset mid-frame
    send_bits(8'h02, 2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_abort", int'(locked), 0);
    idle(3, 1'b1);
    send_bits(SW, 8, 1'b1);
    send_bits(8'h5A, 6, 1'b0);
    do_reset();

    // Random traffic with injected sync words, random stalls, aborts and clears
    for (int n = 0; n < 3000; n++) begin
      if (pend.size() == 0) begin
        if ($urandom_range(5) == 0) begin
          for (int i = 7; i >= 0; i--) pend.push_back(SW[i]);
        end else begin
          for (int i = 0; i < 4; i++) pend.push_back(1'($urandom_range(1)));
        end
      end
      v = ($urandom_range(3) != 0);
      b = v ? pend.pop_front() : 1'($urandom_range(1));
      step(b, v, ($urandom_range(299) != 0), ($urandom_range(2) != 0),
           ($urandom_range(39) == 0));
    end
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
